slow_memory_arb: RTL and testbench

SLOW_MEMORY_ARB -- requirements
Module: slow_memory_arb

---
 rtl/slow_memory_arb.sv | 154 +++++++++++++++
 tb/tb_slow_memory_arb.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/slow_memory_arb.sv
// Round-robin arbiter in front of a fixed-latency line store shared by NUM_PORTS cache channels.
// One transaction at a time: IDLE grants, WAIT counts down LATENCY edges, DONE strobes mem_ready.
module slow_memory_arb #(
    parameter int NUM_PORTS  = 2,
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 28,
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 5,
    localparam int GW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_PORTS-1:0]          mem_read,
    input  logic [NUM_PORTS-1:0]          mem_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   mem_addr,
    input  logic [NUM_PORTS*LINE_W-1:0]   mem_wdata,
    output logic [NUM_PORTS*LINE_W-1:0]   mem_rdata,
    output logic [NUM_PORTS-1:0]          mem_ready,
    output logic                          busy,
    output logic [GW-1:0]                 grant_id,
    output logic [15:0]                   txn_count,
    output logic [7:0]                    abort_count,
    output logic [1:0]                    dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

    state_t                      state_q, state_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic [GW-1:0]               rr_q, rr_d;
    logic [GW-1:0]               gnt_q, gnt_d;
    logic [DEPTH_LOG2-1:0]       idx_q, idx_d;
    logic [LINE_W-1:0]           wdata_q, wdata_d;
    logic                        wr_q, wr_d;
    logic [NUM_PORTS*LINE_W-1:0] rdata_q, rdata_d;
    logic [15:0]                 txn_q, txn_d;
    logic [7:0]                  abort_q, abort_d;

    logic [NUM_PORTS-1:0] req;
    logic                 sel_found;
    logic [GW-1:0]        sel;
    logic [GW-1:0]        cand;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 unused_addr_bits;

    assign req              = mem_read | mem_write;
    assign sel_addr         = mem_addr[sel*ADDR_W +: ADDR_W];
    assign unused_addr_bits = ^sel_addr;

    // Search begins one past the last grant so every requester is reached within NUM_PORTS grants.
    always_comb begin
        sel_found = 1'b0;
        sel       = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = GW'((int'(rr_q) + i) % NUM_PORTS);
            if (!sel_found && req[cand]) begin
                sel_found = 1'b1;
                sel       = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        txn_d   = txn_q;
        abort_d = abort_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                    rr_d    = sel;
                    gnt_d   = sel;
                    idx_d   = sel_addr[DEPTH_LOG2-1:0];
                    wdata_d = mem_wdata[sel*LINE_W +: LINE_W];
                    wr_d    = mem_write[sel];
                end
            end
            WAIT: begin
                if (!req[gnt_q]) begin
                    state_d = IDLE;
                    if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
                end else if (cnt_q == 8'd0) begin
                    state_d = DONE;
                    // Captured here so the slice is valid throughout DONE and holds afterwards.
                    if (!wr_q) rdata_d[gnt_q*LINE_W +: LINE_W] = mem[idx_q];
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (txn_q != 16'hFFFF) txn_d = txn_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rr_q    <= GW'(NUM_PORTS - 1);
            gnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            txn_q   <= '0;
            abort_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            txn_q   <= txn_d;
            abort_q <= abort_d;
        end
    end

    // Storage is never reset; reset forces state to IDLE so a pending write cannot commit.
    always_ff @(posedge clk) begin
        if (rst_n && state_q == DONE && wr_q) mem[idx_q] <= wdata_q;
    end

    always_comb begin
        mem_ready = '0;
        if (state_q == DONE) mem_ready[gnt_q] = 1'b1;
    end

    assign mem_rdata   = rdata_q;
    assign busy        = (state_q != IDLE);
    assign grant_id    = gnt_q;
    assign txn_count   = txn_q;
    assign abort_count = abort_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_slow_memory_arb.sv
// Directed bench for slow_memory_arb: read/write, round-robin contention, address wrap, abort and reset.
module tb_slow_memory_arb;

    localparam int NP  = 2;
    localparam int LW  = 128;
    localparam int AW  = 28;
    localparam int LAT = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NP-1:0]    mem_read, mem_write;
    logic [NP*AW-1:0] mem_addr;
    logic [NP*LW-1:0] mem_wdata;
    logic [NP*LW-1:0] mem_rdata;
    logic [NP-1:0]    mem_ready;
    logic             busy;
    logic [0:0]       grant_id;
    logic [15:0]      txn_count;
    logic [7:0]       abort_count;
    logic [1:0]       dbg_state;

    int checks = 0;
    int errors = 0;

    slow_memory_arb #(
        .NUM_PORTS(NP), .LINE_W(LW), .ADDR_W(AW), .DEPTH_LOG2(8), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .grant_id(grant_id),
        .txn_count(txn_count), .abort_count(abort_count),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge in the following IDLE cycle.
    task automatic do_txn(input int p, input bit w, input logic [AW-1:0] a,
                          input logic [LW-1:0] d, output logic [LW-1:0] r);
        int n;
        logic [NP-1:0] one;
        one = 2'b01 << p;
        check("pre_idle", busy, 0);
        mem_read[p]             = !w;
        mem_write[p]            = w;
        mem_addr[p*AW +: AW]    = a;
        mem_wdata[p*LW +: LW]   = d;
        @(negedge clk);
        check("grant_busy", busy, 1);
        check("grant_id", grant_id, p);
        mem_addr[p*AW +: AW]  = AW'($urandom);
        mem_wdata[p*LW +: LW] = {4{$urandom}};
        n = 0;
        while (mem_ready[p] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, LAT);
        check("ready_onehot", mem_ready, one);
        r = mem_rdata[p*LW +: LW];
        mem_read[p]  = 1'b0;
        mem_write[p] = 1'b0;
        @(negedge clk);
        check("ready_pulse", mem_ready, 0);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    logic [LW-1:0] r;
    int ev;
    int last;

    initial begin
        rst_n     = 1'b0;
        mem_read  = '0;
        mem_write = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", mem_ready, 0);
        check("rst_rdata0", mem_rdata[LW-1:0], 0);
        check("rst_rdata1", mem_rdata[2*LW-1:LW], 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_txn", txn_count, 0);
        check("rst_abort", abort_count, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Preload mem[3] through the write path, then reset: storage must survive.
        do_txn(0, 1'b1, 28'd3, 128'hA5, r);
        reset_pulse();
        check("txn_after_rst", txn_count, 0);

        do_txn(0, 1'b0, 28'd3, '0, r);
        check("read3", r, 128'hA5);
        check("txn_1", txn_count, 1);

        do_txn(1, 1'b1, 28'd7, 128'h1234, r);
        do_txn(1, 1'b0, 28'd7, '0, r);
        check("read7", r, 128'h1234);
        check("txn_3", txn_count, 3);
        check("hold_p0", mem_rdata[LW-1:0], 128'hA5);

        do_txn(0, 1'b1, 28'h100, 128'hDEAD_BEEF, r);
        do_txn(0, 1'b0, 28'h000, '0, r);
        check("wrap", r, 128'hDEAD_BEEF);
        check("txn_5", txn_count, 5);

        // Contention: both ports hold read requests continuously from just after reset.
        reset_pulse();
        mem_addr[0 +: AW]  = 28'd3;
        mem_addr[AW +: AW] = 28'd7;
        mem_read = 2'b11;
        ev   = 0;
        last = 0;
        for (int k = 1; k <= 60 && ev < 4; k++) begin
            @(negedge clk);
            if (mem_ready != 0) begin
                check("cont_port", mem_ready, (ev % 2 == 0) ? 2'b01 : 2'b10);
                if (ev == 0) check("cont_first", k, LAT + 1);
                else         check("cont_gap", k - last, LAT + 2);
                if (ev % 2 == 0) check("cont_rd0", mem_rdata[LW-1:0], 128'hA5);
                else             check("cont_rd1", mem_rdata[2*LW-1:LW], 128'h1234);
                last = k;
                ev++;
            end
        end
        mem_read = '0;
        check("cont_events", ev, 4);
        @(negedge clk);
        check("cont_txn", txn_count, 4);

        // Abort: write dropped mid-WAIT must not commit or strobe ready.
        do_txn(0, 1'b1, 28'd5, 128'h55, r);
        mem_write[0]       = 1'b1;
        mem_addr[0 +: AW]  = 28'd5;
        mem_wdata[0 +: LW] = 128'hBAD;
        @(negedge clk);
        check("abort_busy", busy, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("abort_noready", mem_ready, 0);
        end
        mem_write[0] = 1'b0;
        @(negedge clk);
        check("abort_busy_fall", busy, 0);
        check("abort_ready", mem_ready, 0);
        check("abort_count", abort_count, 1);
        do_txn(0, 1'b0, 28'd5, '0, r);
        check("abort_mem", r, 128'h55);
        check("txn_6", txn_count, 6);

        // Reset in the middle of a port-1 write.
        mem_write[1]        = 1'b1;
        mem_addr[AW +: AW]  = 28'd5;
        mem_wdata[LW +: LW] = 128'hCAFE;
        @(negedge clk);
        check("rw_busy", busy, 1);
        check("rw_grant", grant_id, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rw_busy0", busy, 0);
        check("rw_ready0", mem_ready, 0);
        check("rw_grant0", grant_id, 0);
        check("rw_txn0", txn_count, 0);
        check("rw_abort0", abort_count, 0);
        check("rw_rdata0", mem_rdata[LW-1:0], 0);
        check("rw_rdata1", mem_rdata[2*LW-1:LW], 0);
        mem_write[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_txn(0, 1'b0, 28'd5, '0, r);
        check("rw_mem", r, 128'h55);
        check("rw_txn1", txn_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
